egress_merger: RTL
==================

EGRESS_MERGER -- requirements
Module: egress_merger

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low (0 = reset, 1 = run).
REQ-003 SHALL have ports empty_d0 and empty_d1, input, 1 bit each: D0/D1 FIFO empty flags.
REQ-004 SHALL have ports data_out0 and data_out1, input, 6 bits each: D0/D1 FIFO read data, valid the cycle after a pop.
REQ-005 SHALL have ports pop_D0 and pop_D1, output, 1 bit each: single-cycle pop request to D0/D1.
REQ-006 SHALL have port ready_egress, input, 1 bit: sink accepts the word when high together with valid_egress.
REQ-007 SHALL have port valid_egress, output, 1 bit: data_egress and port_egress hold a word.
REQ-008 SHALL have port data_egress, output, 6 bits: merged output word.
REQ-009 SHALL have port port_egress, output, 1 bit: source of the word (0 = D0, 1 = D1).
REQ-010 SHALL have port idle_egress, output, 1 bit: high in IDLE with both FIFOs empty.
REQ-011 SHALL have ports count_d0 and count_d1, output, 8 bits each: words delivered from D0/D1.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, FETCH, SEND.
REQ-013 In IDLE with a non-empty FIFO granted, the block SHALL assert pop for that FIFO combinationally in that cycle and move to FETCH.
REQ-014 In FETCH, the block SHALL register data_outX into data_egress and the grant into port_egress, then move to SEND; no pop is asserted in FETCH.
REQ-015 In SEND, valid_egress SHALL be 1, and data_egress and port_egress SHALL stay stable until ready_egress=1.
REQ-016 In SEND with ready_egress=1: if a FIFO is non-empty, the block SHALL pop it in the same cycle and go to FETCH; otherwise it SHALL go to IDLE.
REQ-017 Arbitration SHALL be round-robin on a last_grant bit: when both FIFOs are non-empty, grant the one not last granted; when only one is non-empty, grant it.
REQ-018 last_grant SHALL update only on a cycle in which a pop is issued.
REQ-019 A pop SHALL never be asserted to a FIFO whose empty flag is 1 in that cycle, and pop_D0 and pop_D1 SHALL never be high together.
REQ-020 Latency SHALL be: pop at cycle T, valid_egress at T+2; peak throughput is one word per 2 cycles.
REQ-021 valid_egress SHALL be 0 in IDLE and FETCH.
REQ-022 On each accepted word (valid_egress & ready_egress), the count for port_egress SHALL increment by 1, wrapping 255 -> 0.

Reset
REQ-023 While reset=0, the block SHALL be in IDLE and SHALL drive: pop_D0=0, pop_D1=0, valid_egress=0, data_egress=0, port_egress=0, counts=0, last_grant=1 (D0 wins first), and idle_egress reflects the empty flags.
REQ-024 Reset asserted mid-operation (FETCH or SEND) SHALL discard the in-flight word immediately, with no completion handshake.

Configuration
REQ-025 Macro EGRESS_COUNT_EN SHALL control the counters: when defined, count_d0/count_d1 operate per REQ-022.
REQ-026 When EGRESS_COUNT_EN is undefined, count_d0/count_d1 SHALL be tied to 0, with no counter flops, and all other behaviour unchanged.

Verification
REQ-027 SHALL cover: after reset, D0 holds 3 words (0x01, 0x02, 0x03), D1 empty, ready_egress=1 -> egress delivers 0x01, 0x02, 0x03 with port 0, one word per 2 cycles, then IDLE with idle_egress=1.
REQ-028 SHALL cover: D0 holds {0x0A, 0x0B}, D1 holds {0x2A, 0x2B}, ready=1 -> order 0x0A(0), 0x2A(1), 0x0B(0), 0x2B(1).
REQ-029 SHALL cover: word 0x15 in SEND with ready_egress=0 for 5 cycles -> data stays 0x15, valid stays 1, no pop asserted, then accepted on the first cycle ready=1.
REQ-030 SHALL cover: reset driven low during FETCH -> valid_egress=0 and pops=0 immediately, and after release the first word comes from D0.
REQ-031 SHALL cover, with EGRESS_COUNT_EN: 257 words from D1 -> count_d1=1, count_d0=0; without it, both counts stay 0.
REQ-032 SHALL cover: random empty flags and ready over 500 cycles -> no pop while empty, never both pops high, and egress stream equals the per-FIFO input order.

Source files
------------

// File: rtl/egress_merger.sv
// egress_merger: round-robin merge of FIFOs D0/D1 onto one valid/ready egress; counters under `EGRESS_COUNT_EN.
// Latency: pop at T, valid_egress at T+2; at most one word per 2 cycles.
// Backpressure: word held stable in SEND until ready_egress; no pop is issued while it is held.
module egress_merger (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty_d0,
  input  logic       empty_d1,
  input  logic [5:0] data_out0,
  input  logic [5:0] data_out1,
  output logic       pop_D0,
  output logic       pop_D1,
  input  logic       ready_egress,
  output logic       valid_egress,
  output logic [5:0] data_egress,
  output logic       port_egress,
  output logic       idle_egress,
  output logic [7:0] count_d0,
  output logic [7:0] count_d1
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   any_ne;
  logic   gnt;
  logic   pop_en;

  always_comb begin
    any_ne = !empty_d0 || !empty_d1;
    // With a single non-empty source, empty_d0 is exactly the index of that source.
    if (!empty_d0 && !empty_d1) gnt = !last_grant_q;
    else                        gnt = empty_d0;
  end

  always_comb begin
    state_d      = state_q;
    pop_en       = 1'b0;
    valid_egress = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_ne) begin
          pop_en  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        valid_egress = 1'b1;
        if (ready_egress) begin
          if (any_ne) begin
            pop_en  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps pops low even while the flags show data during reset.
  assign pop_D0      = pop_en && reset && !gnt;
  assign pop_D1      = pop_en && reset && gnt;
  assign idle_egress = (state_q == IDLE) && empty_d0 && empty_d1;

  // last_grant_q also names the source of the word currently in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      data_egress  <= 6'd0;
      port_egress  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop_en) last_grant_q <= gnt;
      if (state_q == FETCH) begin
        data_egress <= last_grant_q ? data_out1 : data_out0;
        port_egress <= last_grant_q;
      end
    end
  end

`ifdef EGRESS_COUNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (valid_egress && ready_egress) begin
      if (port_egress) cnt1_q <= cnt1_q + 8'd1;
      else             cnt0_q <= cnt0_q + 8'd1;
    end
  end

  assign count_d0 = cnt0_q;
  assign count_d1 = cnt1_q;
`else
  assign count_d0 = 8'd0;
  assign count_d1 = 8'd0;
`endif

endmodule
